// File: rtl/video_pkg.sv
// Shared video definitions: visible line width, FIFO word layout and
// line-buffer bank states.
package video_pkg;

    localparam int LINE_WIDTH = 256;

    localparam int X_MSB   = 32;
    localparam int X_LSB   = 24;
    localparam int RGB_MSB = 23;
    localparam int RGB_LSB = 0;
    localparam int X_W     = X_MSB - X_LSB + 1;
    localparam int FIFO_W  = X_MSB + 1;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    function automatic logic [X_W-1:0] word_x(input logic [FIFO_W-1:0] word);
        return word[X_MSB:X_LSB];
    endfunction

    function automatic logic [RGB_MSB:0] word_rgb(input logic [FIFO_W-1:0] word);
        return word[RGB_MSB:RGB_LSB];
    endfunction

endpackage

// File: rtl/line_buffer_controller_if.sv
// Signal bundle between the line-buffer controller and its environment
// (CDC pixel FIFO, line-buffer RAM and VGA scan-out).
interface line_buffer_controller_if #(
    parameter int ADDR_W = 8
);
    import video_pkg::*;

    logic              fifo_empty;
    logic              fifo_rd_rst_busy;
    logic [FIFO_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              line_done;
    logic              line_ready;
    logic              rd_bank;
    logic [7:0]        sync_errors;

    modport master (
        input  fifo_empty, fifo_rd_rst_busy, fifo_data, line_done,
        output fifo_rd_en, wr_en, wr_bank, wr_addr, wr_data,
               line_ready, rd_bank, sync_errors
    );

    modport slave (
        output fifo_empty, fifo_rd_rst_busy, fifo_data, line_done,
        input  fifo_rd_en, wr_en, wr_bank, wr_addr, wr_data,
               line_ready, rd_bank, sync_errors
    );

endinterface

// File: rtl/line_bank_state.sv
// FREE -> FILLING -> FULL -> FREE occupancy tracker for one line-buffer bank.
// The next state is exported so the controller can plan FIFO reads ahead.
module line_bank_state
    import video_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_write,
    input  logic        i_write_last,
    input  logic        i_release,
    output bank_state_e o_state,
    output bank_state_e o_state_nxt
);

    bank_state_e r_state;
    bank_state_e w_state_nxt;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= BANK_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BANK_FREE: begin
                if (i_write) begin
                    w_state_nxt = i_write_last ? BANK_FULL : BANK_FILLING;
                end else begin
                    w_state_nxt = BANK_FREE;
                end
            end
            BANK_FILLING: begin
                if (i_write_last) begin
                    w_state_nxt = BANK_FULL;
                end else begin
                    w_state_nxt = BANK_FILLING;
                end
            end
            BANK_FULL: begin
                if (i_release) begin
                    w_state_nxt = BANK_FREE;
                end else begin
                    w_state_nxt = BANK_FULL;
                end
            end
            default: w_state_nxt = BANK_FREE;
        endcase
    end

    assign o_state     = r_state;
    assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/line_buffer_controller.sv
// Drains the CDC pixel FIFO into a two-bank line buffer, checking the x
// sequence of every word and handing complete lines to the VGA side.
module line_buffer_controller
    import video_pkg::*;
#(
    parameter int LINE_WIDTH = video_pkg::LINE_WIDTH,
    parameter int ADDR_W     = 8
) (
    input  logic              i_clk_25mhz,
    input  logic              i_reset_n,
    input  logic              i_fifo_empty,
    input  logic              i_fifo_rd_rst_busy,
    input  logic [32:0]       i_fifo_data,
    output logic              o_fifo_rd_en,
    output logic              o_wr_en,
    output logic              o_wr_bank,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [23:0]       o_wr_data,
    input  logic              i_line_done,
    output logic              o_line_ready,
    output logic              o_rd_bank,
    output logic [7:0]        o_sync_errors
);

    localparam logic [X_W-1:0]    X_LIMIT  = X_W'(LINE_WIDTH);
    localparam logic [ADDR_W-1:0] LAST_X   = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic              r_fifo_rd_en, r_valid, r_wr_ptr, r_rd_bank;
    logic              r_wr_en, r_wr_bank, r_line_ready;
    logic [ADDR_W-1:0] r_expected, r_wr_addr;
    logic [23:0]       r_wr_data;
    logic [7:0]        r_sync_errors;

    logic [X_W-1:0]    w_x;
    logic [23:0]       w_rgb;
    logic [ADDR_W-1:0] w_x_addr, w_exp_nxt, w_wr_addr_nxt;
    logic [23:0]       w_wr_data_nxt;
    logic [7:0]        w_err_cnt_nxt;
    logic              w_wr_en_nxt, w_err, w_line_last, w_done, w_pop_now;
    logic              w_wr_ptr_nxt, w_rd_bank_nxt, w_rd_en_nxt, w_line_ready_nxt;
    bank_state_e       w_state0, w_state1, w_state0_nxt, w_state1_nxt;
    bank_state_e       w_cur_state, w_next_wr_state, w_next_rd_state;

    assign w_x      = word_x(i_fifo_data);
    assign w_rgb    = word_rgb(i_fifo_data);
    assign w_x_addr = w_x[ADDR_W-1:0];

    // A FULL write bank never receives data; the read planner keeps that from happening.
    assign w_cur_state = r_wr_ptr ? w_state1 : w_state0;

    // Classify the captured word: in-sequence write, restart at x=0, discard or error
    always_comb begin
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_exp_nxt     = r_expected;
        w_err         = 1'b0;
        w_line_last   = 1'b0;
        if (r_valid && (w_cur_state != BANK_FULL)) begin
            if (w_x >= X_LIMIT) begin
                w_err = 1'b0;
            end else if (w_x_addr == r_expected) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = w_x_addr;
                w_wr_data_nxt = w_rgb;
                if (r_expected == LAST_X) begin
                    w_line_last = 1'b1;
                    w_exp_nxt   = ADDR_ZERO;
                end else begin
                    w_exp_nxt   = r_expected + ADDR_ONE;
                end
            end else if (w_x_addr == ADDR_ZERO) begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = ADDR_ZERO;
                w_wr_data_nxt = w_rgb;
                w_exp_nxt     = ADDR_ONE;
                w_err         = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end else begin
            w_wr_en_nxt = 1'b0;
        end
    end

    line_bank_state u_bank0 (
        .i_clk        (i_clk_25mhz),
        .i_reset_n    (i_reset_n),
        .i_write      (w_wr_en_nxt & ~r_wr_ptr),
        .i_write_last (w_line_last & ~r_wr_ptr),
        .i_release    (w_done & ~r_rd_bank),
        .o_state      (w_state0),
        .o_state_nxt  (w_state0_nxt)
    );

    line_bank_state u_bank1 (
        .i_clk        (i_clk_25mhz),
        .i_reset_n    (i_reset_n),
        .i_write      (w_wr_en_nxt & r_wr_ptr),
        .i_write_last (w_line_last & r_wr_ptr),
        .i_release    (w_done & r_rd_bank),
        .o_state      (w_state1),
        .o_state_nxt  (w_state1_nxt)
    );

    assign w_done          = i_line_done & r_line_ready;
    assign w_wr_ptr_nxt    = r_wr_ptr ^ w_line_last;
    assign w_rd_bank_nxt   = r_rd_bank ^ w_done;
    assign w_next_wr_state = w_wr_ptr_nxt ? w_state1_nxt : w_state0_nxt;
    assign w_next_rd_state = w_rd_bank_nxt ? w_state1_nxt : w_state0_nxt;
    assign w_pop_now       = r_fifo_rd_en & ~i_fifo_empty & ~i_fifo_rd_rst_busy;

    // The strobe is registered, so plan one word ahead: hold off when the word
    // now leaving the FIFO could be the one that fills the bank.
    assign w_rd_en_nxt = ~i_fifo_empty & ~i_fifo_rd_rst_busy
                       & (w_next_wr_state != BANK_FULL)
                       & ~(w_pop_now & (w_exp_nxt == LAST_X));

    assign w_line_ready_nxt = (w_next_rd_state == BANK_FULL);
    assign w_err_cnt_nxt    = (w_err && (r_sync_errors != 8'hFF)) ? (r_sync_errors + 8'd1)
                                                                  : r_sync_errors;

    // Pipeline, pointers and all output registers
    always_ff @(posedge i_clk_25mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fifo_rd_en  <= 1'b0;
            r_valid       <= 1'b0;
            r_expected    <= ADDR_ZERO;
            r_wr_ptr      <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_wr_addr     <= ADDR_ZERO;
            r_wr_data     <= 24'd0;
            r_line_ready  <= 1'b0;
            r_sync_errors <= 8'd0;
        end else begin
            r_fifo_rd_en  <= w_rd_en_nxt;
            r_valid       <= w_pop_now;
            r_expected    <= w_exp_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_bank     <= w_rd_bank_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_bank     <= w_wr_en_nxt ? r_wr_ptr : r_wr_bank;
            r_wr_addr     <= w_wr_addr_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_line_ready  <= w_line_ready_nxt;
            r_sync_errors <= w_err_cnt_nxt;
        end
    end

    assign o_fifo_rd_en  = r_fifo_rd_en;
    assign o_wr_en       = r_wr_en;
    assign o_wr_bank     = r_wr_bank;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_line_ready  = r_line_ready;
    assign o_rd_bank     = r_rd_bank;
    assign o_sync_errors = r_sync_errors;

endmodule

// File: tb/tb_line_buffer_controller.sv
// Self-checking bench for line_buffer_controller: FIFO model plus a write
// scoreboard, a table of sequence-error vectors and hand-written corner cases.
module tb_line_buffer_controller;
    import video_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    line_buffer_controller_if #(.ADDR_W(8)) bus();

    line_buffer_controller #(.LINE_WIDTH(256), .ADDR_W(8)) dut (
        .i_clk_25mhz        (clk),
        .i_reset_n          (rst_n),
        .i_fifo_empty       (bus.fifo_empty),
        .i_fifo_rd_rst_busy (bus.fifo_rd_rst_busy),
        .i_fifo_data        (bus.fifo_data),
        .o_fifo_rd_en       (bus.fifo_rd_en),
        .o_wr_en            (bus.wr_en),
        .o_wr_bank          (bus.wr_bank),
        .o_wr_addr          (bus.wr_addr),
        .o_wr_data          (bus.wr_data),
        .i_line_done        (bus.line_done),
        .o_line_ready       (bus.line_ready),
        .o_rd_bank          (bus.rd_bank),
        .o_sync_errors      (bus.sync_errors)
    );

    typedef struct {
        int x;
        bit wr;
        int errs;
    } vec_t;

    logic [32:0] fifo_q[$];
    logic [32:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    bit pend_pop = 1'b0;
    bit rd_seen  = 1'b0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    function automatic logic [23:0] rgb_of(input int x, input int tag);
        return {8'(x * 3 + tag), 8'(tag * 17), 8'(x)};
    endfunction

    task automatic push(input int x, input int tag, input bit wr, input bit bank);
        logic [23:0] c;
        c = rgb_of(x, tag);
        fifo_q.push_back({9'(x), c});
        if (wr) exp_q.push_back({bank, 8'(x), c});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 bus.line_done = 1'b1;
        @(posedge clk); #1 bus.line_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},  32'(bus.fifo_rd_en),  32'd0);
        chk({tag, "_wr_en"},  32'(bus.wr_en),       32'd0);
        chk({tag, "_wr_bank"},32'(bus.wr_bank),     32'd0);
        chk({tag, "_wr_addr"},32'(bus.wr_addr),     32'd0);
        chk({tag, "_wr_data"},32'(bus.wr_data),     32'd0);
        chk({tag, "_ready"},  32'(bus.line_ready),  32'd0);
        chk({tag, "_rd_bank"},32'(bus.rd_bank),     32'd0);
        chk({tag, "_errors"}, 32'(bus.sync_errors), 32'd0);
    endtask

    // FIFO model: one-cycle read latency, reads ignored while empty or busy
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_pop = 1'b0;
        end else if (pend_pop && fifo_q.size() > 0) begin
            bus.fifo_data = fifo_q.pop_front();
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        pend_pop = rst_n && bus.fifo_rd_en && !bus.fifo_empty && !bus.fifo_rd_rst_busy;
    end

    // Write scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (bus.fifo_rd_en) rd_seen = 1'b1;
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: got write bank %0d addr %0d, want no write",
                             bus.wr_bank, bus.wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_bank", 32'(bus.wr_bank), 32'(e[32]));
                    chk("wr_addr", 32'(bus.wr_addr), 32'(e[31:24]));
                    chk("wr_data", 32'(bus.wr_data), 32'(e[23:0]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int m_exp;
        vecs[0] = '{0,   1'b1, 1};
        vecs[1] = '{1,   1'b1, 1};
        vecs[2] = '{2,   1'b1, 1};
        vecs[3] = '{5,   1'b0, 2};
        vecs[4] = '{3,   1'b1, 2};
        vecs[5] = '{300, 1'b0, 2};
        vecs[6] = '{256, 1'b0, 2};
        vecs[7] = '{4,   1'b1, 2};
        vecs[8] = '{4,   1'b0, 3};
        vecs[9] = '{0,   1'b1, 4};

        rst_n = 1'b0;
        bus.fifo_rd_rst_busy = 1'b0;
        bus.line_done = 1'b0;
        bus.fifo_data = 33'd0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Full line into bank 0
        for (int x = 0; x < 256; x++) push(x, 1, 1'b1, 1'b0);
        wait_drain("line0");
        chk("line0_ready", 32'(bus.line_ready), 32'd1);
        chk("line0_rd_bank", 32'(bus.rd_bank), 32'd0);
        chk("line0_errors", 32'(bus.sync_errors), 32'd0);

        // Second line into bank 1, then both banks full: reads must stall
        for (int x = 0; x < 256; x++) push(x, 2, 1'b1, 1'b1);
        wait_drain("line1");
        for (int x = 0; x < 10; x++) push(x, 3, 1'b1, 1'b0);
        rd_seen = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_no_rd_en", 32'(rd_seen), 32'd0);
        chk("stall_no_writes", 32'(exp_q.size()), 32'd10);
        pulse_done();
        chk("release_rd_bank", 32'(bus.rd_bank), 32'd1);
        chk("release_ready", 32'(bus.line_ready), 32'd1);
        wait_drain("resume");

        // Last write of bank 0 coincides with line_done for bank 1
        for (int x = 10; x < 255; x++) push(x, 3, 1'b1, 1'b0);
        wait_drain("fill0");
        push(255, 3, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.fifo_rd_en && fifo_q.size() > 0) && n < 50);
        chk("coincide_rd_wait", 32'(n < 50), 32'd1);
        pulse_done();
        chk("coincide_ready", 32'(bus.line_ready), 32'd1);
        chk("coincide_rd_bank", 32'(bus.rd_bank), 32'd0);
        wait_drain("coincide");
        chk("coincide_ready_hold", 32'(bus.line_ready), 32'd1);

        // Release bank 0; a further line_done with nothing ready is ignored
        pulse_done();
        chk("empty_ready", 32'(bus.line_ready), 32'd0);
        chk("empty_rd_bank", 32'(bus.rd_bank), 32'd1);
        pulse_done();
        chk("ignored_done_rd_bank", 32'(bus.rd_bank), 32'd1);
        chk("ignored_done_ready", 32'(bus.line_ready), 32'd0);

        // Sequence errors in bank 1
        for (int x = 0; x < 100; x++) push(x, 4, 1'b1, 1'b1);
        wait_drain("pre_table");
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].x, 5, vecs[i].wr, 1'b1);
            wait_drain("vec");
            chk($sformatf("vec%0d_errors", i), 32'(bus.sync_errors), 32'(vecs[i].errs));
        end

        // Out-of-line x interleaved with valid pixels: no error increments
        m_exp = 1;
        for (int x = 256; x <= 340; x++) begin
            push(x, 6, 1'b0, 1'b1);
            if (x % 17 == 0) begin
                push(m_exp, 6, 1'b1, 1'b1);
                m_exp++;
            end
        end
        wait_drain("oob");
        chk("oob_errors", 32'(bus.sync_errors), 32'd4);
        for (int x = m_exp; x < 256; x++) push(x, 7, 1'b1, 1'b1);
        wait_drain("fill1");
        chk("fill1_ready", 32'(bus.line_ready), 32'd1);
        chk("fill1_rd_bank", 32'(bus.rd_bank), 32'd1);

        // Error counter saturation
        for (int i = 0; i < 260; i++) push(7, 8, 1'b0, 1'b0);
        wait_drain("saturate");
        chk("saturate_errors", 32'(bus.sync_errors), 32'd255);

        // Reset mid-line, then FIFO reset-busy holds reads off
        pulse_done();
        chk("pre_reset_ready", 32'(bus.line_ready), 32'd0);
        for (int x = 0; x < 128; x++) push(x, 9, 1'b1, 1'b0);
        wait_drain("half_line");
        for (int x = 128; x < 141; x++) push(x, 9, 1'b1, 1'b0);
        n = 0;
        while (exp_q.size() > 8 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #3 rst_n = 1'b0;
        bus.fifo_rd_rst_busy = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        #1 chk_reset_outputs("midline_reset");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd_seen = 1'b0;
        push(0, 10, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_no_rd_en", 32'(rd_seen), 32'd0);
        chk("busy_no_writes", 32'(exp_q.size()), 32'd1);
        bus.fifo_rd_rst_busy = 1'b0;
        wait_drain("after_reset");
        chk("after_reset_errors", 32'(bus.sync_errors), 32'd0);
        chk("after_reset_ready", 32'(bus.line_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
